// File: rtl/uart_echo_fifo.sv
// UART loopback: 2-flop synchronised receiver, FIFO, re-serialising transmitter.
// Define UART_ECHO_UPPER_EN to upper-case a..z on the echo path (DATA_BITS=8).
module uart_echo_fifo #(
   parameter int BAUDRATE  = 104,
   parameter int DATA_BITS = 8,
   parameter int DEPTH     = 16,
   parameter int MODE      = 0,
   localparam int AW       = $clog2(DEPTH)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx,
   output logic                 tx,
   output logic [DATA_BITS-1:0] ledb,
   output logic                 rcv,
   output logic                 frame_err,
   output logic                 overflow,
   output logic [AW:0]          level
);

   localparam int CW = $clog2(BAUDRATE);
   localparam int BW = $clog2(DATA_BITS);
   localparam logic [CW-1:0] LAST  = CW'(BAUDRATE - 1);
   localparam logic [CW-1:0] HALF  = CW'(BAUDRATE / 2);
   localparam logic [BW-1:0] BLAST = BW'(DATA_BITS - 1);
   localparam logic [AW:0]   FULL  = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} st_t;

   function automatic logic [DATA_BITS-1:0] conv(input logic [DATA_BITS-1:0] c);
`ifdef UART_ECHO_UPPER_EN
      if (DATA_BITS == 8 && c >= DATA_BITS'(8'h61) && c <= DATA_BITS'(8'h7a))
         return c - DATA_BITS'(8'h20);
`endif
      return c;
   endfunction

   logic s1, s2, s3, fall;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1 <= 1'b1;
         s2 <= 1'b1;
         s3 <= 1'b1;
      end else begin
         s1 <= rx;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign fall = s3 & ~s2;

   st_t                 rs, rs_n;
   logic [CW-1:0]       rc, rc_n;
   logic [BW-1:0]       rb, rb_n;
   logic [DATA_BITS-1:0] rsh, rsh_n;
   logic                push, ferr;

   always_comb begin
      rs_n  = rs;
      rc_n  = rc + CW'(1);
      rb_n  = rb;
      rsh_n = rsh;
      push  = 1'b0;
      ferr  = 1'b0;
      unique case (rs)
         IDLE: begin
            rc_n = '0;
            if (fall) rs_n = START;
         end
         START: if (rc == HALF) begin
            rc_n = '0;
            rb_n = '0;
            rs_n = s2 ? IDLE : DATA;
         end
         DATA: if (rc == LAST) begin
            rc_n  = '0;
            rb_n  = rb + BW'(1);
            rsh_n = {s2, rsh[DATA_BITS-1:1]};
            if (rb == BLAST) rs_n = STOP;
         end
         STOP: if (rc == LAST) begin
            rc_n = '0;
            rs_n = IDLE;
            push = s2;
            ferr = ~s2;
         end
         default: rs_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rs        <= IDLE;
         rc        <= '0;
         rb        <= '0;
         rsh       <= '0;
         rcv       <= 1'b0;
         frame_err <= 1'b0;
         ledb      <= '0;
      end else begin
         rs        <= rs_n;
         rc        <= rc_n;
         rb        <= rb_n;
         rsh       <= rsh_n;
         rcv       <= push;
         frame_err <= ferr;
         if (push) ledb <= rsh;
      end
   end

   logic [DATA_BITS-1:0] mem [DEPTH];
   logic [AW-1:0]        wp, rp;
   logic                 pop, push_ok, go;

   // A full FIFO still accepts a push when the same edge pops.
   assign push_ok = push & ((level != FULL) | pop);
   assign go      = (MODE == 0) && (level != '0);

   always_ff @(posedge clk) begin
      if (push_ok) mem[wp] <= rsh;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wp       <= '0;
         rp       <= '0;
         level    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push_ok) wp <= wp + AW'(1);
         if (pop) rp <= rp + AW'(1);
         if (push_ok && !pop) level <= level + (AW+1)'(1);
         else if (!push_ok && pop) level <= level - (AW+1)'(1);
         if (push && !push_ok) overflow <= 1'b1;
      end
   end

   st_t                  ts, ts_n;
   logic [CW-1:0]        tc, tc_n;
   logic [BW-1:0]        tb, tb_n;
   logic [DATA_BITS-1:0] tsh, tsh_n;
   logic                 txq, txq_n;

   // txq is registered from the current state, so every bit is delayed one cycle.
   always_comb begin
      ts_n  = ts;
      tc_n  = tc + CW'(1);
      tb_n  = tb;
      tsh_n = tsh;
      pop   = 1'b0;
      txq_n = 1'b1;
      unique case (ts)
         IDLE: begin
            tc_n = '0;
            if (go) begin
               pop   = 1'b1;
               tsh_n = conv(mem[rp]);
               ts_n  = START;
            end
         end
         START: begin
            txq_n = 1'b0;
            if (tc == LAST) begin
               tc_n = '0;
               tb_n = '0;
               ts_n = DATA;
            end
         end
         DATA: begin
            txq_n = tsh[0];
            if (tc == LAST) begin
               tc_n  = '0;
               tb_n  = tb + BW'(1);
               tsh_n = tsh >> 1;
               if (tb == BLAST) ts_n = STOP;
            end
         end
         STOP: if (tc == LAST) begin
            tc_n = '0;
            ts_n = IDLE;
            if (go) begin
               pop   = 1'b1;
               tsh_n = conv(mem[rp]);
               ts_n  = START;
            end
         end
         default: ts_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ts  <= IDLE;
         tc  <= '0;
         tb  <= '0;
         tsh <= '0;
         txq <= 1'b1;
      end else begin
         ts  <= ts_n;
         tc  <= tc_n;
         tb  <= tb_n;
         tsh <= tsh_n;
         txq <= txq_n;
      end
   end

   assign tx = (MODE == 1) ? rx : txq;

endmodule

// File: doc/uart_echo_fifo.md
Name: uart_echo_fifo

Overview:
- Parametrised UART loopback: deserialises `rx`, buffers characters in a FIFO, and re-serialises them on `tx`.
- Next generation of the board's echo test, adding configurable data width, buffer depth, echo mode, framing/overflow reporting and last-character display on the LEDs.
- Sits at top level between the serial pins and the user LEDs.

Parameters:
- BAUDRATE, 104, clock cycles per bit (104 = 115200 baud at 12 MHz); must be >= 4.
- DATA_BITS, 8, data bits per frame (5..9), LSB first, no parity, 1 stop bit.
- DEPTH, 16, FIFO entries; power of two, >= 2; AW = log2(DEPTH).
- MODE, 0, 0 = buffered echo via FIFO; 1 = raw passthrough (`tx` follows `rx` combinationally), receiver still runs.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- rx  in  1  serial input, idle high
- tx  out  1  serial output, idle high
- ledb  out  DATA_BITS  last correctly received character
- rcv  out  1  one-cycle pulse per accepted character
- frame_err  out  1  one-cycle pulse when a stop bit samples 0
- overflow  out  1  sticky: a character was dropped because the FIFO was full
- level  out  AW+1  current FIFO occupancy, 0..DEPTH

Behaviour:
- Reset values (asynchronous; also applies mid-frame):
  - `tx`=1 (MODE 0), `ledb`=0, `rcv`=0, `frame_err`=0, `overflow`=0, `level`=0.
  - Both FSMs go to IDLE, FIFO is emptied, any partial frame is discarded.
- RX input: `rx` passes through a 2-flop synchroniser, reset to 1. All RX timing refers to the synchronised signal.
- RX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: a falling edge starts the bit counter.
  - START: at count BAUDRATE/2, sample. If 1, it was a glitch: return to IDLE with no pulse. If 0, go to DATA.
  - DATA: sample every BAUDRATE cycles, DATA_BITS times, shifting LSB first.
  - STOP: sample after another BAUDRATE cycles.
    - Stop = 1: `rcv` pulses one cycle, `ledb` updates, the character is pushed. All three happen on the same edge.
    - Stop = 0: `frame_err` pulses, character dropped, `ledb` unchanged.
  - After the stop sample, RX returns to IDLE immediately and waits for the next falling edge. Back-to-back frames are supported.
- FIFO:
  - Push while `level`==DEPTH: data is dropped and `overflow` sets. `overflow` stays set until reset.
  - Push and pop in the same cycle: both take effect, `level` unchanged. This holds at full (push accepted) and at empty (no pop, since TX only pops when `level`>0 before the edge).
  - Pointers are AW bits and wrap modulo DEPTH.
- TX FSM: IDLE -> START -> DATA -> STOP -> IDLE, each bit exactly BAUDRATE cycles.
  - IDLE with `level`>0: pop the head into the shift register. `tx` drives the start bit (0) from the next edge.
  - Latency: character pushed into an empty FIFO at edge N -> `tx` falls at edge N+2.
  - Data bits go out LSB first, then 1 stop bit (1).
  - After the stop bit, with `level`>0, the next start bit follows with no idle gap.
- MODE 1:
  - `tx` = `rx` (raw pin, combinational); the TX FSM never pops.
  - The FIFO fills, `level` saturates at DEPTH, `overflow` sets on the (DEPTH+1)th character.
  - `ledb`, `rcv` and `frame_err` behave as in MODE 0.

Optional Feature:
- Macro UART_ECHO_UPPER_EN.
- Defined, with DATA_BITS=8: characters 0x61..0x7A are converted to 0x41..0x5A when loaded into the TX shift register. The FIFO, `ledb` and `level` still hold the unmodified received code.
- Not defined, or DATA_BITS != 8: echo is bit-exact.

Test Plan:
- BAUDRATE=8, DEPTH=4, MODE 0: send 0x55 on `rx` -> `rcv` pulses once, `ledb`=0x55, `level` goes 1 then back to 0, `tx` reproduces 0x55 frame starting 2 cycles after `rcv`, each bit 8 cycles.
- Send 0x41, 0x42, 0x43 back-to-back -> echoed back-to-back with no idle gap between frames; `level` peaks at 1; `overflow` stays 0.
- Hold `tx` pathway busy, MODE 1, DEPTH=4, send 5 characters 0x01..0x05 -> `level`=4, `overflow`=1 after the 5th, `ledb`=0x05; `tx` mirrors `rx` throughout.
- Send frame 0xA5 with stop bit forced 0 -> `frame_err` pulses once, `rcv` stays 0, `ledb` unchanged, `level` unchanged.
- 2-cycle low glitch on idle `rx` -> no `rcv`, no `frame_err`, RX back in IDLE; a following valid 0x3C is received correctly.
- Assert `rst` mid-way through TX of 0x7E with 2 queued characters -> `tx`=1 immediately, `level`=0, `overflow`=0, `ledb`=0; no further TX after release. With UART_ECHO_UPPER_EN, sending 0x61 echoes 0x41 while `ledb`=0x61.
